// File: rtl/load_store_unit.sv
// load_store_unit: RISC-V load/store sequencer over an 8-byte-line memory, with read-modify-write for partial stores
module load_store_unit #(
  parameter int MEM_BYTES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [63:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  state_t st;
  logic        store_q, err_q;
  logic [2:0]  f3_q;
  logic [63:0] addr_q, wdata_q, line_q, rdata_q;
  logic [3:0]  req_sz, sz;
  logic        req_err;
  logic [7:0]  bm;
  logic [63:0] wm, sh, ld_data;
  always_comb begin
    req_sz = 4'd1 << req_funct3[1:0];
    // 65-bit sum so a line address near the top of the space cannot wrap into range
    req_err = ((req_addr[2:0] & 3'(req_sz - 4'd1)) != 3'd0)
            | (({1'b0, req_addr[63:3], 3'b000} + 65'd8) > 65'(MEM_BYTES))
            | (req_store & req_funct3[2])
            | (!req_store & (req_funct3 == 3'b111));
    sz = 4'd1 << f3_q[1:0];
    bm = 8'(((16'd1 << sz) - 16'd1) << addr_q[2:0]);
    for (int k = 0; k < 8; k++) wm[k*8 +: 8] = {8{bm[k]}};
    sh = mem_rdata >> {addr_q[2:0], 3'b000};
    ld_data = f3_q == 3'b000 ? {{56{sh[7]}}, sh[7:0]} :
              f3_q == 3'b001 ? {{48{sh[15]}}, sh[15:0]} :
              f3_q == 3'b010 ? {{32{sh[31]}}, sh[31:0]} :
              f3_q == 3'b100 ? {56'd0, sh[7:0]} :
              f3_q == 3'b101 ? {48'd0, sh[15:0]} :
              f3_q == 3'b110 ? {32'd0, sh[31:0]} : sh;
  end
  assign req_ready  = st == IDLE;
  assign resp_valid = st == RESP;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_read   = st == READ;
  assign mem_write  = (st == WRITE) & !reset;
  assign mem_addr   = {addr_q[63:3], 3'b000};
  assign mem_wdata  = (line_q & ~wm) | ((wdata_q << {addr_q[2:0], 3'b000}) & wm);
  always_ff @(posedge clk) begin
    if (reset) begin
      st      <= IDLE;
      store_q <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      line_q  <= '0;
      rdata_q <= '0;
    end else begin
      case (st)
        IDLE: if (req_valid) begin
          store_q <= req_store;
          f3_q    <= req_funct3;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          rdata_q <= '0;
          err_q   <= req_err;
          st      <= req_err ? RESP : READ;
        end
        READ: begin
          line_q  <= mem_rdata;
          rdata_q <= store_q ? '0 : ld_data;
          st      <= store_q ? WRITE : RESP;
        end
        WRITE: st <= RESP;
        RESP: if (resp_ready) begin
          rdata_q <= '0;
          err_q   <= 1'b0;
          st      <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store controller between the core's memory stage and the byte-addressed 64-bit data memory. It takes one RISC-V load or store per request handshake and aligns the access to an 8-byte line. Loads are extracted and sign- or zero-extended from that line. Sub-doubleword stores are done as line read-modify-write, because the memory always writes 8 bytes.

## Interface
Parameters:
- MEM_BYTES, 64, data memory size in bytes; multiple of 8.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- req_valid  input  1  core request valid.
- req_ready  output  1  unit can accept a request.
- req_store  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V funct3 (size/sign).
- req_addr  input  64  byte address.
- req_wdata  input  64  store data, right-aligned.
- resp_valid  output  1  response valid.
- resp_ready  input  1  core accepts response.
- resp_rdata  output  64  extended load data; 0 for stores/errors.
- resp_err  output  1  access misaligned, out of range or illegal funct3.
- mem_addr  output  64  line address to memory (req_addr & ~7).
- mem_wdata  output  64  merged line to memory.
- mem_read  output  1  memory read enable.
- mem_write  output  1  memory write enable, sampled on clk rise.
- mem_rdata  input  64  combinational line read; byte lane k = byte at mem_addr+k.

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE: req_ready=1. On req_valid&req_ready, latch store, funct3, addr, wdata.
  - Error: go to RESP with err=1.
  - Otherwise: go to READ.
- Size = 1 << funct3[1:0]; off = addr[2:0].
- Error if any of:
  - misaligned: off & (size-1) != 0;
  - out of range: (addr & ~7) + 8 > MEM_BYTES;
  - store with funct3[2]=1;
  - load funct3 = 111.
- READ: mem_read=1, mem_addr=line address. Capture mem_rdata into line register.
  - Load: go to RESP.
  - Store: go to WRITE.
- Load extract: field = line[off*8 +: size*8].
  - funct3 000/001/010 (lb/lh/lw): sign-extend to 64 bits.
  - 100/101/110 (lbu/lhu/lwu): zero-extend.
  - 011 (ld): full line.
- WRITE: mem_write=1, mem_addr=line address. mem_wdata = line with bytes off..off+size-1 replaced by req_wdata[size*8-1:0]; other bytes unchanged. Next state RESP.
- RESP: resp_valid=1 with resp_rdata/resp_err held stable. On resp_ready, go to IDLE.
- mem_read=0 and mem_write=0 in all other states. mem_addr and mem_wdata are don't-care when both enables are 0.
- No request is accepted outside IDLE; req_ready=0 in READ/WRITE/RESP.

## Timing
- Reset (sampled high at a rising edge):
  - state IDLE; all outputs 0 except req_ready=1; line/resp registers cleared.
  - Aborts any in-flight access without response.
- mem_write = (state==WRITE) & !reset, so a reset coinciding with WRITE suppresses the memory write.
- Counting from the accepting edge E0, resp_valid is first high in the cycle after:
  - error: E0 (0 memory cycles);
  - load: E0+1;
  - store: E0+2.
- Response is consumed on the edge where resp_valid&resp_ready. req_ready goes high in the following cycle.
- Minimum throughput is one load per 3 cycles and one store per 4 cycles.
- Errors never assert mem_read or mem_write.
- resp_ready held low keeps RESP indefinitely with stable outputs.
- Memory contents are unaffected by loads.

## Test plan
- Memory preloaded with byte10=0x01, byte20=0x02, rest 0:
  - ld @8 -> resp_rdata=0x0000_0000_0001_0000, err=0, resp 2 cycles after accept;
  - lh @10 -> 0x0000_0000_0000_0001.
- sb 0x80 @17, then:
  - lb @17 -> 0xFFFF_FFFF_FFFF_FF80;
  - lbu @17 -> 0x0000_0000_0000_0080;
  - ld @16 -> 0x0000_0002_0000_8000 (byte20 preserved).
- Error cases, each with mem_read=mem_write=0 throughout:
  - sw 0xDEADBEEF @6 -> resp_err=1, rdata=0, resp 1 cycle after accept;
  - ld @64 -> resp_err=1.
- sd 0x1122_3344_5566_7788 @40, then:
  - lwu @44 -> 0x0000_0000_1122_3344;
  - lh @40 -> 0x0000_0000_0000_7788.
- Backpressure: load with resp_ready low 3 cycles -> resp_valid/resp_rdata stable, req_ready=0. A second req_valid held high is accepted only the cycle after the response handshake.
- Reset during the WRITE cycle of sh 0xFFFF @0 -> no mem_write edge, memory bytes 0..1 remain 0. Next cycle req_ready=1 and resp_valid=0.
